bc_param_ctrl: RTL and testbench
================================

# bc_param_ctrl

Frame-synchronous parameter controller for the contrast/brightness stage. It turns four raw push-button inputs into saturating 8-bit CONTRAST and BRIGHT settings and their enable flags. New values are applied only at a Vsync edge, so the downstream contrast core never changes gain or offset mid-frame. It sits directly upstream of the contrast/brightness stage and drives its CONTRAST, BRIGHT, CONTRAST_SIG and BRIGHT_SIG inputs.

## Interface
Parameters:
- DEB_CYCLES, 1_000_000: consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
- STEP, 8: increment/decrement per accepted press.
- VS_POL, 1: active level of Vsync; 1 means the frame boundary is the rising edge.

Ports:
- Pclk  in  1  pixel clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- Vsync  in  1  frame sync, same timing as the video into the contrast stage.
- key_con_up  in  1  raw button, active-high, asynchronous to Pclk.
- key_con_dn  in  1  raw button, same electrical properties as key_con_up.
- key_bri_up  in  1  raw button, same electrical properties as key_con_up.
- key_bri_dn  in  1  raw button, same electrical properties as key_con_up.
- CONTRAST  out  8  gain, Q1.7 format; 128 = 1.0.
- BRIGHT  out  8  offset-binary offset; 128 = 0.
- CONTRAST_SIG  out  1  contrast enable; high when CONTRAST != 128.
- BRIGHT_SIG  out  1  brightness enable; high when BRIGHT != 128.

## Operation
- **Input conditioning:** each key passes through a 2-flop synchronizer, then a debouncer.
- **Debouncer:**
  - Counter clears whenever the synced input equals the stable state.
  - Stable state toggles once the synced input has differed for DEB_CYCLES consecutive cycles.
  - Each 0→1 transition of the stable state produces a one-cycle press pulse.
- **Shadow registers:** con_sh and bri_sh, reset to 128. Update rules, with 9-bit intermediate arithmetic:
  - up press: sh = min(sh+STEP, 255).
  - dn press: sh = max(sh−STEP, 0); the underflow check uses the borrow bit.
  - up and dn presses for the same channel in the same cycle: sh = 128 (restore neutral).
  - Contrast and brightness presses in the same cycle: each channel is updated independently.
- **Frame apply:** on the Vsync frame-boundary edge (detected with a registered Vsync), copy con_sh to CONTRAST and bri_sh to BRIGHT.
  - SIG outputs are registered from the same compare, so they change in the same cycle as their value.
  - A press landing in the same cycle as the Vsync edge goes to the shadow only and is applied at the next frame edge.
- **Reset:** mid-operation Rst on a clock edge returns all state to reset values, including debouncer stable states. A key held across reset must be released and pressed again to count.

## Timing
- **Reset values:** CONTRAST=128, BRIGHT=128, CONTRAST_SIG=0, BRIGHT_SIG=0, all shadows 128, all debouncer stable states 0, all counters 0.
- **Key to shadow:** 2 sync cycles, then DEB_CYCLES cycles, then 1 cycle for the press pulse, then 1 cycle to update the shadow.
- **Shadow to outputs:** outputs update 1 cycle after the first Pclk edge that samples the Vsync boundary edge.
- **Vsync:** the first Vsync edge after reset applies whatever is in the shadows, normally 128.
- **Counters:** debounce counters saturate and never wrap.

## Configuration
- Macro BC_FRAME_SYNC_EN.
- **Defined:** behaviour exactly as described above; outputs change only at Vsync boundaries.
- **Undefined:**
  - The shadow registers act as the outputs directly, so values change 1 cycle after the press pulse.
  - Vsync is ignored and the Vsync edge detector is removed.
  - For bring-up only.

## Structure
- **Package bc_param_pkg:**
  - NEUTRAL = 8'd128.
  - Default STEP and DEB_CYCLES values.
  - A function `sat_step(val, up, dn)` returning the next shadow value.
- **Sub-module key_debounce:**
  - Contains the synchronizer, counter, stable state and press pulse.
  - Parameterized by DEB_CYCLES.
  - Instantiated four times.
- **Top level:** holds the shadows, edge detect and output registers.

## Test plan
All scenarios use DEB_CYCLES=4, STEP=8, VS_POL=1.
- **Single press:** one key_con_up press, held 10 cycles, then a Vsync pulse → con_sh=136. CONTRAST changes 128→136 and CONTRAST_SIG goes to 1 one cycle after the Vsync rise. No output change before Vsync.
- **Glitch rejection:** 3-cycle pulses on key_bri_dn → no press pulse; BRIGHT stays 128 across two frames.
- **Saturation:**
  - 17 key_con_up presses → 255 (the last press is clamped).
  - 17 key_bri_dn presses from 128 → 0; the 17th press keeps 0, with no wrap to 248.
- **Simultaneous up and dn:** from CONTRAST=200, key_con_up and key_con_dn pressed simultaneously → shadow=128; after Vsync CONTRAST=128 and CONTRAST_SIG=0.
- **Press on the Vsync edge:** press pulse coincides with the Vsync edge → value appears one frame later.
- **Reset with key held:** Rst asserted 1 cycle while key_con_up is held → all outputs return to reset values next cycle. No press is registered until the key is released and pressed again.

Source files
------------

// File: rtl/bc_param_pkg.sv
// Shared constants and the saturating step helper for the contrast/brightness parameter controller.
package bc_param_pkg;

   localparam logic [7:0] NEUTRAL        = 8'd128;
   localparam int         DEF_STEP       = 8;
   localparam int         DEF_DEB_CYCLES = 1_000_000;

   // Next shadow value; 9-bit intermediates expose the carry/borrow for clamping.
   function automatic logic [7:0] sat_step(input logic [7:0] val,
                                           input logic       up,
                                           input logic       dn,
                                           input logic [7:0] step);
      logic [8:0] sum;
      logic [8:0] diff;
      logic [7:0] res;
      sum  = {1'b0, val} + {1'b0, step};
      diff = {1'b0, val} - {1'b0, step};
      res  = val;
      if (up && dn) begin
         res = NEUTRAL;
      end else if (up) begin
         res = sum[8] ? 8'hFF : sum[7:0];
      end else if (dn) begin
         res = diff[8] ? 8'h00 : diff[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button input: 2-flop synchronizer, saturating debounce counter,
// stable state and a one-cycle press pulse on each accepted 0->1 change.
module key_debounce
   import bc_param_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic press_o
);

   localparam int             CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CW-1:0]  CMAX = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [1:0]    fill_q;
   logic          arm_q, arm_d;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q >= CMAX) begin
         stable_d = ~stable_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // A key still held from before reset must be seen released before it can press.
      arm_d   = arm_q | (fill_q[1] & ~sync2_q);
      press_d = stable_d & ~stable_q & arm_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         fill_q   <= 2'b00;
         arm_q    <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= key_i;
         sync2_q  <= sync1_q;
         fill_q   <= {fill_q[0], 1'b1};
         arm_q    <= arm_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/bc_param_ctrl.sv
// Frame-synchronous CONTRAST/BRIGHT controller driven by four debounced keys.
// Macro BC_FRAME_SYNC_EN: defined = apply shadows at Vsync edges; undefined = shadows drive outputs directly.
module bc_param_ctrl
   import bc_param_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int STEP       = DEF_STEP,
   parameter bit VS_POL     = 1'b1
) (
   input  logic       Pclk,
   input  logic       Rst,
   input  logic       Vsync,
   input  logic       key_con_up,
   input  logic       key_con_dn,
   input  logic       key_bri_up,
   input  logic       key_bri_dn,
   output logic [7:0] CONTRAST,
   output logic [7:0] BRIGHT,
   output logic       CONTRAST_SIG,
   output logic       BRIGHT_SIG
);

   localparam logic [7:0] STEP8 = 8'(STEP);

   logic       con_up_w, con_dn_w, bri_up_w, bri_dn_w;
   logic [7:0] con_sh_q, con_sh_d;
   logic [7:0] bri_sh_q, bri_sh_d;
   logic       con_sig_q, bri_sig_q;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_con_up (
      .clk_i(Pclk), .rst_i(Rst), .key_i(key_con_up), .press_o(con_up_w));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_con_dn (
      .clk_i(Pclk), .rst_i(Rst), .key_i(key_con_dn), .press_o(con_dn_w));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_bri_up (
      .clk_i(Pclk), .rst_i(Rst), .key_i(key_bri_up), .press_o(bri_up_w));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_bri_dn (
      .clk_i(Pclk), .rst_i(Rst), .key_i(key_bri_dn), .press_o(bri_dn_w));

   always_comb begin
      con_sh_d = sat_step(con_sh_q, con_up_w, con_dn_w, STEP8);
      bri_sh_d = sat_step(bri_sh_q, bri_up_w, bri_dn_w, STEP8);
   end

   always_ff @(posedge Pclk) begin
      if (Rst) begin
         con_sh_q <= NEUTRAL;
         bri_sh_q <= NEUTRAL;
      end else begin
         con_sh_q <= con_sh_d;
         bri_sh_q <= bri_sh_d;
      end
   end

`ifdef BC_FRAME_SYNC_EN
   logic       vs_q, vs_qq;
   logic       frame_w;
   logic [7:0] con_out_q, bri_out_q;

   assign frame_w = VS_POL ? (vs_q & ~vs_qq) : (~vs_q & vs_qq);

   // The outputs take the shadow as it was before this cycle's press, if any.
   always_ff @(posedge Pclk) begin
      if (Rst) begin
         vs_q      <= 1'b0;
         vs_qq     <= 1'b0;
         con_out_q <= NEUTRAL;
         bri_out_q <= NEUTRAL;
         con_sig_q <= 1'b0;
         bri_sig_q <= 1'b0;
      end else begin
         vs_q  <= Vsync;
         vs_qq <= vs_q;
         if (frame_w) begin
            con_out_q <= con_sh_q;
            bri_out_q <= bri_sh_q;
            con_sig_q <= (con_sh_q != NEUTRAL);
            bri_sig_q <= (bri_sh_q != NEUTRAL);
         end
      end
   end

   assign CONTRAST = con_out_q;
   assign BRIGHT   = bri_out_q;
`else
   logic unused_vsync;
   assign unused_vsync = Vsync ^ VS_POL;

   always_ff @(posedge Pclk) begin
      if (Rst) begin
         con_sig_q <= 1'b0;
         bri_sig_q <= 1'b0;
      end else begin
         con_sig_q <= (con_sh_d != NEUTRAL);
         bri_sig_q <= (bri_sh_d != NEUTRAL);
      end
   end

   assign CONTRAST = con_sh_q;
   assign BRIGHT   = bri_sh_q;
`endif

   assign CONTRAST_SIG = con_sig_q;
   assign BRIGHT_SIG   = bri_sig_q;

endmodule

// File: tb/tb_bc_param_ctrl.sv
// Directed bench for bc_param_ctrl with DEB_CYCLES=4, STEP=8, VS_POL=1; follows BC_FRAME_SYNC_EN.
module tb_bc_param_ctrl;

   logic       Pclk = 1'b0;
   logic       Rst  = 1'b1;
   logic       Vsync = 1'b0;
   logic [3:0] keys = 4'b0000;
   logic [7:0] CONTRAST, BRIGHT;
   logic       CONTRAST_SIG, BRIGHT_SIG;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 Pclk = ~Pclk;

   bc_param_ctrl #(.DEB_CYCLES(4), .STEP(8), .VS_POL(1'b1)) dut (
      .Pclk(Pclk), .Rst(Rst), .Vsync(Vsync),
      .key_con_up(keys[0]), .key_con_dn(keys[1]),
      .key_bri_up(keys[2]), .key_bri_dn(keys[3]),
      .CONTRAST(CONTRAST), .BRIGHT(BRIGHT),
      .CONTRAST_SIG(CONTRAST_SIG), .BRIGHT_SIG(BRIGHT_SIG));

   task automatic tick(input int n);
      repeat (n) @(posedge Pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         keys[k] = 1'b1;
         tick(10);
         keys[k] = 1'b0;
         tick(10);
      end
   endtask

   task automatic frame();
      Vsync = 1'b1;
      tick(4);
      Vsync = 1'b0;
      tick(4);
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      tick(1);
      Rst = 1'b0;
      tick(3);
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_contrast", CONTRAST, 8'd128);
      chk("rst_bright", BRIGHT, 8'd128);
      chk("rst_con_sig", {7'd0, CONTRAST_SIG}, 8'd0);
      chk("rst_bri_sig", {7'd0, BRIGHT_SIG}, 8'd0);
      Rst = 1'b0;
      tick(3);

      // Single press, applied at the frame edge
      press(0, 1);
`ifdef BC_FRAME_SYNC_EN
      chk("single_pre_vsync", CONTRAST, 8'd128);
      Vsync = 1'b1;
      tick(1);
      chk("single_vsync_sample", CONTRAST, 8'd128);
      tick(1);
      chk("single_after", CONTRAST, 8'd136);
      chk("single_sig", {7'd0, CONTRAST_SIG}, 8'd1);
      tick(2);
      Vsync = 1'b0;
      tick(4);
`else
      chk("single_direct", CONTRAST, 8'd136);
      chk("single_sig", {7'd0, CONTRAST_SIG}, 8'd1);
      frame();
`endif

      // Glitch rejection on key_bri_dn
      do_reset();
      for (int f = 0; f < 2; f++) begin
         keys[3] = 1'b1;
         tick(3);
         keys[3] = 1'b0;
         tick(10);
         frame();
         chk("glitch_bright", BRIGHT, 8'd128);
         chk("glitch_bri_sig", {7'd0, BRIGHT_SIG}, 8'd0);
      end

      // Saturation both ways
      do_reset();
      press(0, 17);
      press(3, 17);
      frame();
      chk("sat_contrast", CONTRAST, 8'd255);
      chk("sat_con_sig", {7'd0, CONTRAST_SIG}, 8'd1);
      chk("sat_bright", BRIGHT, 8'd0);
      chk("sat_bri_sig", {7'd0, BRIGHT_SIG}, 8'd1);

      // Simultaneous up+dn restores neutral
      do_reset();
      press(0, 9);
      frame();
      chk("simul_pre", CONTRAST, 8'd200);
      keys[1:0] = 2'b11;
      tick(10);
      keys[1:0] = 2'b00;
      tick(10);
      frame();
      chk("simul_contrast", CONTRAST, 8'd128);
      chk("simul_con_sig", {7'd0, CONTRAST_SIG}, 8'd0);

      // Press pulse coinciding with the Vsync edge
      do_reset();
      keys[0] = 1'b1;
      tick(5);
      Vsync = 1'b1;
      tick(2);
`ifdef BC_FRAME_SYNC_EN
      chk("edge_press_same_frame", CONTRAST, 8'd128);
`else
      chk("edge_press_direct", CONTRAST, 8'd136);
`endif
      Vsync = 1'b0;
      tick(3);
      keys[0] = 1'b0;
      tick(10);
      frame();
      chk("edge_press_next_frame", CONTRAST, 8'd136);

      // Reset while a key is held
      keys[0] = 1'b1;
      tick(10);
      Rst = 1'b1;
      tick(1);
      Rst = 1'b0;
      chk("rsthold_contrast", CONTRAST, 8'd128);
      chk("rsthold_bright", BRIGHT, 8'd128);
      chk("rsthold_con_sig", {7'd0, CONTRAST_SIG}, 8'd0);
      chk("rsthold_bri_sig", {7'd0, BRIGHT_SIG}, 8'd0);
      tick(20);
      frame();
      chk("rsthold_no_press", CONTRAST, 8'd128);
      chk("rsthold_no_sig", {7'd0, CONTRAST_SIG}, 8'd0);
      keys[0] = 1'b0;
      tick(10);
      press(0, 1);
      frame();
      chk("rsthold_repress", CONTRAST, 8'd136);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
